// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: boot hold, halt/resume, redirect
// priority and a one-deep redirect buffer that survives pipeline stalls.
module pc_unit #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned          INC          = 4,
    parameter int unsigned          ALIGN_BITS   = 2,
    parameter int unsigned          BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            fetch_valid,
    output logic            redirect_pending,
    output logic            halted
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
    localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC);
    localparam logic [CNT_W-1:0] BOOT_INIT = CNT_W'(BOOT_CYCLES);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    pend_tgt_q, pend_tgt_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fetch_valid_q;
    logic               halted_q;
    logic [XLEN-1:0]    redirect_aligned;

    assign redirect_aligned = redirect_target & ALIGN_MASK;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            BOOT: begin
                if (trap_valid) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Priority chain: a halt request only wins when nothing else moves the PC.
            RUN: begin
                if (trap_valid) begin
                    pc_d   = TRAP_VECTOR;
                    pend_d = 1'b0;
                end else if (redirect_valid && !stall) begin
                    pc_d   = redirect_aligned;
                    pend_d = 1'b0;
                end else if (redirect_valid && stall) begin
                    pend_tgt_d = redirect_aligned;
                    pend_d     = 1'b1;
                end else if (pend_q && !stall) begin
                    pc_d   = pend_tgt_q;
                    pend_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt_req) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + INC_VAL;
                end
            end

            HALT: begin
                if (trap_valid) begin
                    pc_d    = TRAP_VECTOR;
                    pend_d  = 1'b0;
                    state_d = RUN;
                end else if (resume) begin
                    state_d = RUN;
                    pend_d  = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redirect_aligned;
                    end else if (pend_q) begin
                        pc_d = pend_tgt_q;
                    end
                end else if (redirect_valid) begin
                    pend_tgt_d = redirect_aligned;
                    pend_d     = 1'b1;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with pc_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_tgt_q    <= '0;
            pend_q        <= 1'b0;
            cnt_q         <= BOOT_INIT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_tgt_q    <= pend_tgt_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= (state_d == RUN);
            halted_q      <= (state_d == HALT);
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus_inc      = pc_q + INC_VAL;
    assign fetch_valid      = fetch_valid_q;
    assign redirect_pending = pend_q;
    assign halted           = halted_q;

endmodule
